adc_capture: RTL

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_capture_if.sv | 24 ++
 rtl/adc_capture_win_stats.sv | 71 +++++++
 rtl/adc_capture.sv | 93 +++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared widths, capture FSM states and the sample magnitude helper for the ADC capture path.
package adc_pkg;

    localparam int ADC_W = 14;
    localparam int CNT_W = 16;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } cap_state_t;

    // |s| clamped to 13 bits: the most negative code would otherwise need a 14th magnitude bit.
    function automatic logic [ADC_W-1:0] magnitude(input logic signed [ADC_W-1:0] s);
        logic [ADC_W-1:0] m;
        if (s[ADC_W-1]) begin
            m = -s;
        end else begin
            m = s;
        end
        if (m[ADC_W-1]) begin
            m = {1'b0, {(ADC_W-1){1'b1}}};
        end
        return m;
    endfunction

endpackage

// File: rtl/adc_capture_if.sv
// Sample input / converted output / window statistics bundle of the ADC capture block.
interface adc_capture_if;
    import adc_pkg::*;

    logic [ADC_W-1:0]        adc_data;
    logic                    out_range;
    logic signed [ADC_W-1:0] out_data;
    logic                    out_valid;
    logic [ADC_W-1:0]        peak;
    logic                    peak_valid;
    logic [CNT_W-1:0]        ovr_count;
    logic                    overload;

    modport master (
        output adc_data, out_range,
        input  out_data, out_valid, peak, peak_valid, ovr_count, overload
    );

    modport slave (
        input  adc_data, out_range,
        output out_data, out_valid, peak, peak_valid, ovr_count, overload
    );

endinterface

// File: rtl/adc_capture_win_stats.sv
// Per-window peak magnitude and saturating over-range count; results load on the closing sample.
module win_stats
    import adc_pkg::*;
#(
    parameter int WIN_LEN    = 4096,
    parameter int OVR_THRESH = 16
) (
    input  logic             clk_40,
    input  logic             rst,
    input  logic [ADC_W-1:0] i_mag,
    input  logic             i_flag,
    input  logic             i_valid,
    output logic [ADC_W-1:0] o_peak,
    output logic [CNT_W-1:0] o_count,
    output logic             o_strobe,
    output logic             o_over
);

    localparam int WW = $clog2(WIN_LEN);

    logic [WW-1:0]    r_win_cnt;
    logic [ADC_W-1:0] r_acc_peak;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [ADC_W-1:0] r_peak;
    logic [CNT_W-1:0] r_count;
    logic             r_strobe;
    logic             r_over;

    logic             w_close;
    logic [ADC_W-1:0] w_peak_new;
    logic [CNT_W-1:0] w_count_new;

    // The closing sample still belongs to its window, so results use the updated accumulator values.
    assign w_close     = (r_win_cnt == WW'(WIN_LEN - 1));
    assign w_peak_new  = (i_mag > r_acc_peak) ? i_mag : r_acc_peak;
    assign w_count_new = (r_acc_cnt == '1) ? r_acc_cnt : r_acc_cnt + CNT_W'(i_flag);

    always_ff @(posedge clk_40) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_acc_peak <= '0;
            r_acc_cnt  <= '0;
            r_peak     <= '0;
            r_count    <= '0;
            r_strobe   <= 1'b0;
            r_over     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (i_valid) begin
                r_win_cnt <= r_win_cnt + WW'(1);
                if (w_close) begin
                    r_peak     <= w_peak_new;
                    r_count    <= w_count_new;
                    r_over     <= (32'(w_count_new) >= 32'(OVR_THRESH));
                    r_strobe   <= 1'b1;
                    r_acc_peak <= '0;
                    r_acc_cnt  <= '0;
                end else begin
                    r_acc_peak <= w_peak_new;
                    r_acc_cnt  <= w_count_new;
                end
            end
        end
    end

    assign o_peak   = r_peak;
    assign o_count  = r_count;
    assign o_strobe = r_strobe;
    assign o_over   = r_over;

endmodule

// File: rtl/adc_capture.sv
// ADC front end: two-stage offset-binary to two's-complement conversion, a post-reset settle
// period that blanks the output, and windowed peak / over-range statistics.
module adc_capture
    import adc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int WIN_LEN       = 4096,
    parameter int OVR_THRESH    = 16
) (
    input  logic          clk_40,
    input  logic          rst,
    adc_capture_if.slave  adc_if
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [ADC_W-1:0]        r_d1;
    logic                    r_or1;
    logic signed [ADC_W-1:0] r_out_data;
    logic                    r_out_valid;
    cap_state_t              r_state;
    logic [SW-1:0]           r_settle_cnt;

    logic signed [ADC_W-1:0] w_sample;
    logic [ADC_W-1:0]        w_mag;
    logic                    w_run;
    logic [ADC_W-1:0]        w_peak;
    logic [CNT_W-1:0]        w_count;
    logic                    w_strobe;
    logic                    w_over;

    assign w_sample = {~r_d1[ADC_W-1], r_d1[ADC_W-2:0]};
    assign w_run    = (r_state == ST_RUN);
    assign w_mag    = magnitude(w_sample);

    always_ff @(posedge clk_40) begin
        if (rst) begin
            r_d1        <= '0;
            r_or1       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_d1        <= adc_if.adc_data;
            r_or1       <= adc_if.out_range;
            r_out_data  <= w_run ? w_sample : '0;
            r_out_valid <= w_run;
        end
    end

    // Once RUN is reached only a reset returns to SETTLE.
    always_ff @(posedge clk_40) begin
        if (rst) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_SETTLE;
            endcase
        end
    end

    // Statistics see the stage-1 sample so their update lands on the same edge as out_data.
    win_stats #(
        .WIN_LEN    (WIN_LEN),
        .OVR_THRESH (OVR_THRESH)
    ) u_win_stats (
        .clk_40   (clk_40),
        .rst      (rst),
        .i_mag    (w_mag),
        .i_flag   (r_or1),
        .i_valid  (w_run),
        .o_peak   (w_peak),
        .o_count  (w_count),
        .o_strobe (w_strobe),
        .o_over   (w_over)
    );

    assign adc_if.out_data   = r_out_data;
    assign adc_if.out_valid  = r_out_valid;
    assign adc_if.peak       = w_peak;
    assign adc_if.peak_valid = w_strobe;
    assign adc_if.ovr_count  = w_count;
    assign adc_if.overload   = w_over;

endmodule
